// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer: synchronises each raw key, debounces press and release,
// and publishes a clean level plus one-cycle press/release/long-press pulses.
module key_debounce_multi #(
    parameter int unsigned N_KEYS       = 4,
    parameter int unsigned DEBOUNCE_CYC = 500_000,
    parameter int unsigned LONG_CYC     = 50_000_000,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic              clk,
    input  logic              timer_rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_pulse
);

    localparam int unsigned MAX_CYC = (DEBOUNCE_CYC > LONG_CYC) ? DEBOUNCE_CYC : LONG_CYC;
    localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FALL = 2'd1,
        HOLD = 2'd2,
        RISE = 2'd3
    } state_t;

    for (genvar i = 0; i < int'(N_KEYS); i++) begin : g_key
        logic          sync1;
        logic          sync2;
        logic          p;
        state_t        state;
        state_t        state_nxt;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nxt;
        logic          long_done;
        logic          long_done_nxt;
        logic          level;
        logic          level_nxt;
        logic          press;
        logic          press_nxt;
        logic          rel;
        logic          rel_nxt;
        logic          lng;
        logic          lng_nxt;

        // Synchroniser resets to the released level so reset never looks like a press.
        always_ff @(posedge clk or posedge timer_rst) begin
            if (timer_rst) begin
                sync1 <= ACTIVE_LOW;
                sync2 <= ACTIVE_LOW;
            end else begin
                sync1 <= key_in[i];
                sync2 <= sync1;
            end
        end

        assign p = ACTIVE_LOW ? ~sync2 : sync2;

        always_ff @(posedge clk or posedge timer_rst) begin
            if (timer_rst) begin
                state     <= IDLE;
                cnt       <= '0;
                long_done <= 1'b0;
                level     <= 1'b0;
                press     <= 1'b0;
                rel       <= 1'b0;
                lng       <= 1'b0;
            end else begin
                state     <= state_nxt;
                cnt       <= cnt_nxt;
                long_done <= long_done_nxt;
                level     <= level_nxt;
                press     <= press_nxt;
                rel       <= rel_nxt;
                lng       <= lng_nxt;
            end
        end

        always_comb begin
            state_nxt     = state;
            cnt_nxt       = cnt;
            long_done_nxt = long_done;
            case (state)
                IDLE: begin
                    if (p) begin
                        state_nxt = FALL;
                        cnt_nxt   = '0;
                    end
                end
                FALL: begin
                    if (!p) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == DEB_LAST) begin
                        state_nxt     = HOLD;
                        cnt_nxt       = '0;
                        long_done_nxt = 1'b0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (!p) begin
                        state_nxt = RISE;
                        cnt_nxt   = '0;
                    end else if (!long_done && cnt == LONG_LAST) begin
                        long_done_nxt = 1'b1;
                    end else if (!long_done) begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                RISE: begin
                    // long_done survives a rejected release bounce: no repeat long press
                    if (p) begin
                        state_nxt = HOLD;
                        cnt_nxt   = '0;
                    end else if (cnt == DEB_LAST) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        always_comb begin
            level_nxt = level;
            press_nxt = 1'b0;
            rel_nxt   = 1'b0;
            lng_nxt   = 1'b0;
            case (state)
                FALL: begin
                    if (p && cnt == DEB_LAST) begin
                        level_nxt = 1'b1;
                        press_nxt = 1'b1;
                    end
                end
                HOLD: begin
                    if (p && !long_done && cnt == LONG_LAST) begin
                        lng_nxt = 1'b1;
                    end
                end
                RISE: begin
                    if (!p && cnt == DEB_LAST) begin
                        level_nxt = 1'b0;
                        rel_nxt   = 1'b1;
                    end
                end
                default: begin
                    level_nxt = level;
                end
            endcase
        end

        assign key_level[i]     = level;
        assign press_pulse[i]   = press;
        assign release_pulse[i] = rel;
        assign long_pulse[i]    = lng;
    end

endmodule
